// File: rtl/eth_dma_rx_mchan.sv
// Multi-channel Ethernet/RAMP RX header stripper: filters frames by MAC/EtherType,
// strips the header, trims padding and queues tagged packets in a show-ahead FIFO.
module eth_dma_rx_mchan #(
    parameter int NCHAN = 4,
    parameter int DEPTH = 16,
    parameter int LENW  = 6,
    localparam int CW   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    in_stype,
    input  logic [31:0]   in_data,
    input  logic [47:0]   mac_addr,
    input  logic          mac_init,
    input  logic          mcast_en,
    input  logic [15:0]   ethertype,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_stype,
    output logic [CW-1:0] out_chan,
    output logic [31:0]   out_data,
    output logic          out_err,
    output logic [15:0]   drop_cnt,
    output logic [15:0]   ovf_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + CW + 32 + 1;
    localparam logic [AW:0] ROOM2_MAX = (AW + 1)'(DEPTH - 2);
    localparam logic [CW-1:0] CHAN_MASK = CW'(NCHAN - 1);
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_END   = 2'd3;

    typedef enum logic [2:0] {S_RESYNC, S_IDLE, S_HDR, S_SEND, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      wcnt_q, wcnt_d;
    logic            bcast_q, bcast_d, mine_q, mine_d, mcast_q, mcast_d;
    logic [LENW-1:0] len_q, len_d, pcnt_q, pcnt_d;
    logic [CW-1:0]   chan_q, chan_d;
    logic [15:0]     drop_q, ovf_q;
    logic            drop_inc, ovf_inc;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     cnt_q;
    logic            push, pop, room2;
    logic [1:0]      push_stype;
    logic [CW-1:0]   push_chan;
    logic [31:0]     push_data;
    logic            push_err;
    logic            accept;
    logic [EW-1:0]   head;

    // Two free slots are needed for anything but an end, so an end always fits.
    assign room2 = (cnt_q <= ROOM2_MAX);
    assign pop   = out_valid & out_ready;

    assign accept = (in_data[15:0] == ethertype) &&
                    (mine_q || (bcast_q && !mac_init) || (mcast_q && !bcast_q && mcast_en));

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        bcast_d    = bcast_q;
        mine_d     = mine_q;
        mcast_d    = mcast_q;
        len_d      = len_q;
        pcnt_d     = pcnt_q;
        chan_d     = chan_q;
        push       = 1'b0;
        push_stype = ST_END;
        push_chan  = chan_q;
        push_data  = 32'd0;
        push_err   = 1'b0;
        drop_inc   = 1'b0;
        ovf_inc    = 1'b0;
        case (state_q)
            S_RESYNC: if (in_stype == ST_END) state_d = S_IDLE;
            S_IDLE: if (in_stype == ST_DATA) begin
                state_d = S_HDR;
                wcnt_d  = 3'd1;
                bcast_d = &in_data;
                mine_d  = (in_data == mac_addr[31:0]);
                mcast_d = in_data[0];
            end
            S_HDR: if (in_stype == ST_END) begin
                state_d = S_IDLE;
            end else if (in_stype == ST_DATA) begin
                wcnt_d = wcnt_q + 3'd1;
                case (wcnt_q)
                    3'd1: begin
                        bcast_d = bcast_q & (in_data[15:0] == 16'hFFFF);
                        mine_d  = mine_q & (in_data[15:0] == mac_addr[47:32]);
                    end
                    3'd3: begin
                        if (accept) begin
                            len_d = in_data[LENW+23:24];
                        end else begin
                            state_d  = S_DROP;
                            drop_inc = 1'b1;
                        end
                    end
                    3'd4: begin
                        if (room2) begin
                            push       = 1'b1;
                            push_stype = ST_START;
                            push_chan  = CW'(in_data[15:8]) & CHAN_MASK;
                            push_data  = {in_data[23:16], in_data[31:24], in_data[15:0]};
                            chan_d     = CW'(in_data[15:8]) & CHAN_MASK;
                            pcnt_d     = '0;
                            state_d    = S_SEND;
                        end else begin
                            ovf_inc = 1'b1;
                            state_d = S_DROP;
                        end
                    end
                    default: ;
                endcase
            end
            S_SEND: if (in_stype == ST_END) begin
                push    = 1'b1;
                state_d = S_IDLE;
            end else if (in_stype == ST_DATA && (pcnt_q < len_q || &len_q)) begin
                push = 1'b1;
                if (room2) begin
                    push_stype = ST_DATA;
                    push_data  = in_data;
                    pcnt_d     = pcnt_q + 1'b1;
                end else begin
                    push_err = 1'b1;
                    ovf_inc  = 1'b1;
                    state_d  = S_DROP;
                end
            end
            S_DROP: if (in_stype == ST_END) state_d = S_IDLE;
            default: state_d = S_RESYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RESYNC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= 16'd0;
            ovf_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
            if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            if (ovf_inc && ovf_q != 16'hFFFF)   ovf_q  <= ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        wcnt_q  <= wcnt_d;
        bcast_q <= bcast_d;
        mine_q  <= mine_d;
        mcast_q <= mcast_d;
        len_q   <= len_d;
        pcnt_q  <= pcnt_d;
        chan_q  <= chan_d;
        if (push) mem_q[wr_ptr_q] <= {push_stype, push_chan, push_data, push_err};
    end

    // Head fields are forced to zero while empty so reset and idle read as all-zero.
    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (cnt_q != '0);
    assign out_stype = out_valid ? head[EW-1 -: 2] : 2'd0;
    assign out_chan  = out_valid ? head[EW-3 -: CW] : '0;
    assign out_data  = out_valid ? head[32:1] : 32'd0;
    assign out_err   = out_valid ? head[0] : 1'b0;
    assign drop_cnt  = drop_q;
    assign ovf_cnt   = ovf_q;
endmodule

// File: tb/tb_eth_dma_rx_mchan.sv
// Directed bench for eth_dma_rx_mchan with NCHAN=4, DEPTH=4, LENW=6.
module tb_eth_dma_rx_mchan;
    localparam int NCHAN = 4;
    localparam int DEPTH = 4;
    localparam int LENW  = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_stype;
    logic [31:0] in_data;
    logic [47:0] mac_addr;
    logic        mac_init, mcast_en;
    logic [15:0] ethertype;
    logic        out_valid, out_ready;
    logic [1:0]  out_stype;
    logic [1:0]  out_chan;
    logic [31:0] out_data;
    logic        out_err;
    logic [15:0] drop_cnt, ovf_cnt;

    int n_asrt = 0;
    int n_fail = 0;
    logic [36:0] mon_q[$];

    localparam logic [31:0] W0U  = 32'h0C0D0E0F;
    localparam logic [31:0] W1U  = 32'h22110A0B;
    localparam logic [31:0] W2   = 32'h66554433;
    localparam logic [31:0] W3L3 = 32'h03000008;
    localparam logic [31:0] W4P5 = 32'h34120511;
    localparam logic [31:0] SOP5 = 32'h12340511;

    eth_dma_rx_mchan #(.NCHAN(NCHAN), .DEPTH(DEPTH), .LENW(LENW)) dut (
        .clk(clk), .reset(reset), .in_stype(in_stype), .in_data(in_data),
        .mac_addr(mac_addr), .mac_init(mac_init), .mcast_en(mcast_en),
        .ethertype(ethertype), .out_valid(out_valid), .out_ready(out_ready),
        .out_stype(out_stype), .out_chan(out_chan), .out_data(out_data),
        .out_err(out_err), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (out_valid && out_ready) mon_q.push_back({out_stype, out_chan, out_data, out_err});

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input int idx, input logic [1:0] st,
                             input logic [1:0] ch, input logic [31:0] d, input logic e);
        logic [63:0] o;
        if (idx < mon_q.size()) o = 64'(mon_q[idx]);
        else o = '1;
        chk(tag, o, 64'({st, ch, d, e}));
    endtask

    task automatic word(input logic [1:0] st, input logic [31:0] d);
        in_stype = st;
        in_data  = d;
        @(posedge clk);
        #1;
        in_stype = 2'd0;
        in_data  = 32'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] w4, input int npay,
                         input logic [31:0] base, input bit gap);
        word(2'd2, w0);
        word(2'd2, w1);
        if (gap) idle(1);
        word(2'd2, w2);
        word(2'd2, w3);
        word(2'd2, w4);
        for (int i = 0; i < npay; i++) word(2'd2, base + 32'(i));
        word(2'd3, 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_stype = 2'd0; in_data = 32'd0;
        mac_addr = 48'h0A0B0C0D0E0F; mac_init = 1'b1; mcast_en = 1'b0;
        ethertype = 16'h0008; out_ready = 1'b1;
        idle(2);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_stype", 64'(out_stype), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ovf", 64'(ovf_cnt), 64'd0);
        reset = 1'b0;

        // Resync: words before the first end are ignored
        word(2'd2, W0U);
        word(2'd3, 32'd0);
        idle(3);
        chk("resync_empty", 64'(mon_q.size()), 64'd0);

        // Unicast, LEN=3, 5 payload words
        mon_q.delete();
        frame(W0U, W1U, W2, W3L3, W4P5, 5, 32'hA0000000, 1'b0);
        idle(4);
        chk("uc_count", 64'(mon_q.size()), 64'd5);
        chk_entry("uc_start", 0, 2'd1, 2'd1, SOP5, 1'b0);
        chk_entry("uc_d0", 1, 2'd2, 2'd1, 32'hA0000000, 1'b0);
        chk_entry("uc_d1", 2, 2'd2, 2'd1, 32'hA0000001, 1'b0);
        chk_entry("uc_d2", 3, 2'd2, 2'd1, 32'hA0000002, 1'b0);
        chk_entry("uc_end", 4, 2'd3, 2'd1, 32'd0, 1'b0);

        // Broadcast with mac_init=0 accepted
        mon_q.delete();
        mac_init = 1'b0;
        frame(32'hFFFFFFFF, 32'h2211FFFF, W2, 32'h01000008, 32'h00010222, 2, 32'hB0000000, 1'b0);
        idle(4);
        chk("bc_count", 64'(mon_q.size()), 64'd3);
        chk_entry("bc_start", 0, 2'd1, 2'd2, 32'h01000222, 1'b0);
        chk_entry("bc_d0", 1, 2'd2, 2'd2, 32'hB0000000, 1'b0);
        chk_entry("bc_end", 2, 2'd3, 2'd2, 32'd0, 1'b0);

        // Broadcast with mac_init=1 dropped
        mon_q.delete();
        mac_init = 1'b1;
        frame(32'hFFFFFFFF, 32'h2211FFFF, W2, 32'h01000008, 32'h00010222, 2, 32'hB0000000, 1'b0);
        idle(4);
        chk("bc_drop_count", 64'(mon_q.size()), 64'd0);
        chk("bc_drop_cnt", 64'(drop_cnt), 64'd1);

        // Multicast with mcast_en=1 accepted
        mon_q.delete();
        mcast_en = 1'b1;
        frame(32'h00005E01, 32'h22110000, W2, 32'h01000008, 32'hCDAB0733, 1, 32'hC0000000, 1'b0);
        idle(4);
        mcast_en = 1'b0;
        chk("mc_count", 64'(mon_q.size()), 64'd3);
        chk_entry("mc_start", 0, 2'd1, 2'd3, 32'hABCD0733, 1'b0);
        chk_entry("mc_d0", 1, 2'd2, 2'd3, 32'hC0000000, 1'b0);
        chk("mc_drop_cnt", 64'(drop_cnt), 64'd1);

        // Wrong EtherType dropped, next valid frame forwarded
        mon_q.delete();
        frame(W0U, W1U, W2, 32'h03000608, W4P5, 2, 32'hE0000000, 1'b0);
        idle(4);
        chk("et_count", 64'(mon_q.size()), 64'd0);
        chk("et_drop_cnt", 64'(drop_cnt), 64'd2);
        frame(W0U, W1U, W2, W3L3, W4P5, 3, 32'hA1000000, 1'b0);
        idle(4);
        chk("et_next_count", 64'(mon_q.size()), 64'd5);
        chk_entry("et_next_start", 0, 2'd1, 2'd1, SOP5, 1'b0);
        chk_entry("et_next_end", 4, 2'd3, 2'd1, 32'd0, 1'b0);

        // Overflow: DEPTH=4, stalled consumer, unlimited length
        mon_q.delete();
        out_ready = 1'b0;
        frame(W0U, W1U, W2, 32'h3F000008, W4P5, 8, 32'hD0000000, 1'b0);
        idle(2);
        chk("ovf_valid", 64'(out_valid), 64'd1);
        chk("ovf_head_stype", 64'(out_stype), 64'd1);
        chk("ovf_head_chan", 64'(out_chan), 64'd1);
        chk("ovf_cnt", 64'(ovf_cnt), 64'd1);
        chk("ovf_nopop", 64'(mon_q.size()), 64'd0);
        idle(2);
        chk("ovf_head_stable", 64'(out_data), 64'(SOP5));
        out_ready = 1'b1;
        idle(6);
        chk("ovf_drain_count", 64'(mon_q.size()), 64'd4);
        chk_entry("ovf_start", 0, 2'd1, 2'd1, SOP5, 1'b0);
        chk_entry("ovf_d0", 1, 2'd2, 2'd1, 32'hD0000000, 1'b0);
        chk_entry("ovf_d1", 2, 2'd2, 2'd1, 32'hD0000001, 1'b0);
        chk_entry("ovf_end", 3, 2'd3, 2'd1, 32'd0, 1'b1);
        chk("ovf_empty", 64'(out_valid), 64'd0);

        // Reset mid-packet at payload word 2
        mon_q.delete();
        word(2'd2, W0U);
        word(2'd2, W1U);
        word(2'd2, W2);
        word(2'd2, W3L3);
        word(2'd2, W4P5);
        word(2'd2, 32'hF0000000);
        word(2'd2, 32'hF0000001);
        reset = 1'b1;
        word(2'd2, 32'hF0000002);
        reset = 1'b0;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_stype", 64'(out_stype), 64'd0);
        chk("mrst_chan", 64'(out_chan), 64'd0);
        chk("mrst_data", 64'(out_data), 64'd0);
        chk("mrst_err", 64'(out_err), 64'd0);
        chk("mrst_drop", 64'(drop_cnt), 64'd0);
        chk("mrst_ovf", 64'(ovf_cnt), 64'd0);
        chk("mrst_popped", 64'(mon_q.size()), 64'd3);
        word(2'd2, 32'hF0000003);
        word(2'd2, 32'hF0000004);
        word(2'd3, 32'd0);
        idle(3);
        chk("mrst_ignored", 64'(mon_q.size()), 64'd3);
        frame(W0U, W1U, W2, W3L3, W4P5, 3, 32'hA2000000, 1'b0);
        idle(4);
        chk("mrst_next_count", 64'(mon_q.size()), 64'd8);
        chk_entry("mrst_next_start", 3, 2'd1, 2'd1, SOP5, 1'b0);
        chk_entry("mrst_next_d2", 6, 2'd2, 2'd1, 32'hA2000002, 1'b0);
        chk_entry("mrst_next_end", 7, 2'd3, 2'd1, 32'd0, 1'b0);

        // Truncated header (end after w2), then a frame with an idle gap
        mon_q.delete();
        word(2'd2, W0U);
        word(2'd2, W1U);
        word(2'd2, W2);
        word(2'd3, 32'd0);
        idle(3);
        chk("short_count", 64'(mon_q.size()), 64'd0);
        chk("short_drop", 64'(drop_cnt), 64'd0);
        frame(W0U, W1U, W2, W3L3, W4P5, 3, 32'hA3000000, 1'b1);
        idle(4);
        chk("short_next_count", 64'(mon_q.size()), 64'd5);
        chk_entry("short_next_start", 0, 2'd1, 2'd1, SOP5, 1'b0);
        chk_entry("short_next_d0", 1, 2'd2, 2'd1, 32'hA3000000, 1'b0);
        chk_entry("short_next_end", 4, 2'd3, 2'd1, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
